// File: rtl/avalon_pio_gen_if.sv
// avalon_pio_gen_if: Avalon-MM slave bus bundle for avalon_pio_gen.
interface avalon_pio_gen_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  modport master(output address, chipselect, write_n, writedata, input readdata);
  modport slave(input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/avalon_pio_gen.sv
// avalon_pio_gen: parametrised Avalon-MM PIO with direction, edge capture and maskable irq.
// Define PIO_BITCLR_EDGE_EN for per-bit edgecapture clear; otherwise any write clears all.
module avalon_pio_gen #(
  parameter int               WIDTH       = 8,
  parameter int               EDGE_TYPE   = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  avalon_pio_gen_if.slave   bus,
  input  logic [WIDTH-1:0]  in_port,
  output logic [WIDTH-1:0]  out_port,
  output logic [WIDTH-1:0]  oe,
  output logic              irq
);
  logic [WIDTH-1:0] sync1, sync2, irqmask, edgecap, edges, wd, rd_mux, out_next, clr;
  logic             wr;
  assign wr  = bus.chipselect & ~bus.write_n;
  assign wd  = bus.writedata[WIDTH-1:0];
  assign irq = |(edgecap & irqmask);
  // sync1/sync2 are the values sync2/prev take at this edge, so the edge lands with sync2
  always_comb begin
    edges    = EDGE_TYPE == 0 ? sync1 & ~sync2 : EDGE_TYPE == 1 ? ~sync1 & sync2 : sync1 ^ sync2;
    rd_mux   = bus.address == 3'd0 ? sync2 : bus.address == 3'd1 ? oe :
               bus.address == 3'd2 ? irqmask : bus.address == 3'd3 ? edgecap : '0;
    out_next = !wr ? out_port : bus.address == 3'd0 ? wd : bus.address == 3'd4 ? out_port | wd :
               bus.address == 3'd5 ? out_port & ~wd : out_port;
`ifdef PIO_BITCLR_EDGE_EN
    clr      = (wr && bus.address == 3'd3) ? wd : '0;
`else
    clr      = (wr && bus.address == 3'd3) ? '1 : '0;
`endif
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1        <= '0;
      sync2        <= '0;
      irqmask      <= '0;
      edgecap      <= '0;
      oe           <= '0;
      out_port     <= RESET_VALUE;
      bus.readdata <= '0;
    end else begin
      sync1        <= in_port;
      sync2        <= sync1;
      edgecap      <= (edgecap & ~clr) | edges;
      out_port     <= out_next;
      bus.readdata <= 32'(rd_mux);
      if (wr && bus.address == 3'd1) oe <= wd;
      if (wr && bus.address == 3'd2) irqmask <= wd;
    end
  end
endmodule

// File: tb/tb_avalon_pio_gen.sv
// tb_avalon_pio_gen: directed checks of avalon_pio_gen with rising-edge and any-edge instances.
module tb_avalon_pio_gen;
  logic        clk = 0, reset_n = 0, cs = 0, wn = 1;
  logic [2:0]  addr = 0;
  logic [31:0] wdat = 0;
  logic [7:0]  inp = 0, out0, oe0, out2, oe2;
  logic        irq0, irq2;
  int          vec = 0, miss = 0;
  avalon_pio_gen_if b0();
  avalon_pio_gen_if b2();
  assign b0.address = addr, b0.chipselect = cs, b0.write_n = wn, b0.writedata = wdat;
  assign b2.address = addr, b2.chipselect = cs, b2.write_n = wn, b2.writedata = wdat;
  avalon_pio_gen #(.WIDTH(8), .EDGE_TYPE(0), .RESET_VALUE(8'hA5)) u0 (
    .clk(clk), .reset_n(reset_n), .bus(b0), .in_port(inp), .out_port(out0), .oe(oe0), .irq(irq0));
  avalon_pio_gen #(.WIDTH(8), .EDGE_TYPE(2), .RESET_VALUE(8'hA5)) u2 (
    .clk(clk), .reset_n(reset_n), .bus(b2), .in_port(inp), .out_port(out2), .oe(oe2), .irq(irq2));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; cs = 1; wn = 0; wdat = d;
    @(posedge clk); #1;
    cs = 0; wn = 1;
  endtask
  task automatic rd(input logic [2:0] a);
    @(negedge clk);
    addr = a;
    @(posedge clk); #1;
  endtask
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    cycles(2);
    chk("rst_out", 32'(out0), 32'hA5);
    chk("rst_oe", 32'(oe0), 0);
    chk("rst_irq", 32'(irq0), 0);
    chk("rst_rd", b0.readdata, 0);
    @(negedge clk) reset_n = 1;
    for (int a = 0; a < 8; a++) begin
      rd(3'(a));
      chk($sformatf("rst_rd%0d", a), b0.readdata, 0);
    end
    wr(0, 32'h0F);  chk("out_wr", 32'(out0), 32'h0F);
    wr(4, 32'hF0);  chk("out_set", 32'(out0), 32'hFF);
    wr(5, 32'h11);  chk("out_clr", 32'(out0), 32'hEE);
    rd(0);          chk("rd_data_is_in", b0.readdata, 0);
    rd(4);          chk("rd_outset", b0.readdata, 0);
    wr(1, 32'hFFFF_FF3C); chk("oe_wr", 32'(oe0), 32'h3C);
    rd(1);          chk("rd_dir", b0.readdata, 32'h3C);
    wr(2, 32'h04);
    @(negedge clk) inp = 8'h04;
    @(posedge clk); #1;
    chk("irq_n", 32'(irq0), 0);
    @(posedge clk); #1;
    chk("irq_n1", 32'(irq0), 1);
    rd(3);          chk("ecap_rise", b0.readdata, 32'h04);
    rd(0);          chk("rd_sync_in", b0.readdata, 32'h04);
    wr(3, 32'hFF);  chk("irq_clr", 32'(irq0), 0);
    @(negedge clk) inp = 8'h00;
    cycles(3);
    rd(3);          chk("no_fall_u0", b0.readdata, 0);
    chk("fall_any_u2", b2.readdata, 32'h04);
    wr(3, 32'hFF);
    wr(2, 32'h00);
    @(negedge clk) inp = 8'h80;
    cycles(3);
    @(negedge clk) inp = 8'h00;
    cycles(3);
    rd(3);          chk("any_b7", b2.readdata, 32'h80);
    chk("masked_irq", 32'(irq2), 0);
    wr(2, 32'h80);  chk("mask_irq", 32'(irq2), 1);
    @(negedge clk) inp = 8'h01;
    cycles(3);
    @(negedge clk) inp = 8'h00;
    cycles(3);
    rd(3);          chk("ecap81", b2.readdata, 32'h81);
    wr(3, 32'h01);
    rd(3);
`ifdef PIO_BITCLR_EDGE_EN
    chk("clr_bit0", b2.readdata, 32'h80);
`else
    chk("clr_all", b2.readdata, 32'h00);
`endif
    @(negedge clk) inp = 8'h81;
    cycles(3);
    @(negedge clk) inp = 8'h00;
    cycles(3);
    wr(3, 32'hFF);
    @(negedge clk) inp = 8'h80;
    cycles(3);
    @(negedge clk) inp = 8'h01;
    cycles(3);
    rd(3);          chk("ecap81_b", b0.readdata, 32'h81);
    @(negedge clk) inp = 8'h00;
    cycles(3);
    @(negedge clk) inp = 8'h01;
    @(posedge clk);
    wr(3, 32'h01);
    rd(3);
`ifdef PIO_BITCLR_EDGE_EN
    chk("set_wins_u0", b0.readdata, 32'h81);
`else
    chk("set_wins_u0", b0.readdata, 32'h01);
`endif
    wr(0, 32'h3C);
    wr(2, 32'hFF);
    chk("pre_rst_irq", 32'(irq2), 1);
    chk("pre_rst_out", 32'(out2), 32'h3C);
    @(negedge clk); #2;
    reset_n = 0;
    #1;
    chk("arst_irq", 32'(irq2), 0);
    chk("arst_out", 32'(out2), 32'hA5);
    chk("arst_oe", 32'(oe2), 0);
    chk("arst_rd", b2.readdata, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
